// File: rtl/sram_like_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter_pkg
//   Shared encodings for the two-master SRAM-like arbiter:
//     - FSM state codes   ARB_IDLE / ARB_ISSUE / ARB_WAIT
//     - owner codes       OWN_IF (instruction fetch) / OWN_MEM (data access)
//     - transfer sizes    SZ_B / SZ_H / SZ_W
//   Owner codes double as bit positions in the one-hot grant vector, so
//   grant[OWN_IF] / grant[OWN_MEM] are the per-requester grant bits.
// -----------------------------------------------------------------------------
package sram_like_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  // Owner of the transaction in flight; also the index into the grant vector
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Transfer size codes carried on data_size / mem_size
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter_if
//   Bundles the three SRAM-like channels seen by the arbiter:
//     inst_*  : instruction-fetch requester (read only)
//     data_*  : data-access requester (read / write)
//     mem_*   : shared port towards the external bus bridge
//     busy    : arbiter has a transaction in flight
//   Modports:
//     slave  - the arbiter's view (serves both requesters, drives the bus)
//     master - the surrounding system's view (core requesters + bus slave)
//
//   Handshake semantics (all channels):
//     A requester raises *_req with its fields and holds req and fields
//     stable until it sees *_addr_ok high in the same cycle; that cycle is
//     the acceptance. Exactly one cycle later or more, *_data_ok pulses high
//     for one cycle with *_rdata valid (reads) or as a write acknowledge.
//     On the bus side the arbiter plays the requester role with mem_req /
//     mem_addr_ok / mem_data_ok. Only one transaction is outstanding.
// -----------------------------------------------------------------------------
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // Instruction-fetch channel
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_W-1:0]     inst_rdata;

  // Data-access channel
  logic                  data_req;
  logic                  data_wr;
  logic [1:0]            data_size;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  // Shared bus channel
  logic                  mem_req;
  logic                  mem_wr;
  logic [1:0]            mem_size;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  // Status
  logic                  busy;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output busy
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/sram_like_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Combinational 2-way grant picker for the SRAM-like arbiter.
//   Ports:
//     inst_req   in   IF request
//     data_req   in   MEM request
//     last_grant in   owner code of the previous grant (round-robin only)
//     grant      out  one-hot grant, bit OWN_IF / bit OWN_MEM
//   Configuration:
//     SRAM_ARB_RR_EN defined   - on contention the grant goes to the
//                                requester that did not win last time
//     SRAM_ARB_RR_EN undefined - MEM always wins on contention
//   A single requester is always granted. The picker does not know the
//   FSM state; the top gates the grant with IDLE.
// -----------------------------------------------------------------------------
module arb_pick
  import sram_like_arbiter_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    grant = 2'b00;
    if (inst_req && data_req) begin
      // Alternate: whoever won last time yields
      if (last_grant == OWN_MEM) begin
        grant[OWN_IF] = 1'b1;
      end else begin
        grant[OWN_MEM] = 1'b1;
      end
    end else if (data_req) begin
      grant[OWN_MEM] = 1'b1;
    end else if (inst_req) begin
      grant[OWN_IF] = 1'b1;
    end
  end
`else
  // History is irrelevant with fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = 2'b00;
    if (data_req) begin
      grant[OWN_MEM] = 1'b1;
    end else if (inst_req) begin
      grant[OWN_IF] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//   Shares one SRAM-like bus port between instruction fetch (IF) and data
//   access (MEM). One transaction is outstanding at a time:
//     IDLE  : pick a winner, assert its addr_ok, capture its request
//     ISSUE : present the captured request on mem_* until mem_addr_ok
//     WAIT  : wait for mem_data_ok
//   The owner's data_ok pulses the cycle after mem_data_ok, with read data
//   already in that requester's rdata register. Writes leave rdata as is.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   synchronous, active-high; drops any transaction
//     bus        slave modport of sram_like_arbiter_if (inst_*, data_*,
//                mem_*, busy)
//     dbg_state  out  current FSM state (ARB_IDLE / ARB_ISSUE / ARB_WAIT)
//
//   Parameters: ADDR_W (address width), DATA_W (data width, strobe DATA_W/8).
//   Must match the parameters of the connected interface instance.
//
//   Configuration macro: SRAM_ARB_RR_EN selects round-robin arbitration on
//   contention; without it MEM has fixed priority.
// -----------------------------------------------------------------------------
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  sram_like_arbiter_if.slave bus,
  output logic [1:0]         dbg_state
);

  localparam int STRB_W = DATA_W / 8;

  // ---------------------------------------------------------------------------
  // State and request registers
  // ---------------------------------------------------------------------------
  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic                owner_q;

  logic                req_wr_q;
  logic [1:0]          req_size_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [STRB_W-1:0]   req_wstrb_q;
  logic [DATA_W-1:0]   req_wdata_q;

  logic [DATA_W-1:0]   inst_rdata_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                inst_data_ok_q;
  logic                data_data_ok_q;

  logic [1:0]          grant;
  logic                last_grant;
  logic                in_idle;
  logic                accept;
  logic                complete;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  arb_pick u_pick (
    .inst_req   (bus.inst_req),
    .data_req   (bus.data_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

`ifdef SRAM_ARB_RR_EN
  // Records who won the most recent grant, contended or not
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= OWN_IF;
    end else if (accept) begin
      last_grant_q <= grant[OWN_MEM] ? OWN_MEM : OWN_IF;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = OWN_IF;
`endif

  assign in_idle = (state_q == ARB_IDLE);

  // Grants are only honoured in IDLE and never while reset is applied, so
  // addr_ok can never reach a requester whose request would then be dropped.
  assign accept = in_idle && !reset && (grant != 2'b00);

  // Completion: bus data returns in WAIT, or together with the address
  // handshake in ISSUE. A lone mem_data_ok in ISSUE or IDLE is not ours.
  assign complete = !reset &&
                    (((state_q == ARB_ISSUE) && bus.mem_addr_ok && bus.mem_data_ok) ||
                     ((state_q == ARB_WAIT)  && bus.mem_data_ok));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.mem_addr_ok) begin
          state_d = bus.mem_data_ok ? ARB_IDLE : ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (bus.mem_data_ok) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state, request capture and response routing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ARB_IDLE;
      owner_q        <= OWN_IF;
      req_wr_q       <= 1'b0;
      req_size_q     <= 2'd0;
      req_addr_q     <= '0;
      req_wstrb_q    <= '0;
      req_wdata_q    <= '0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;

      // One-cycle completion pulses, routed by the captured owner
      inst_data_ok_q <= complete && (owner_q == OWN_IF);
      data_data_ok_q <= complete && (owner_q == OWN_MEM);

      if (accept) begin
        if (grant[OWN_MEM]) begin
          owner_q     <= OWN_MEM;
          req_wr_q    <= bus.data_wr;
          req_size_q  <= bus.data_size;
          req_addr_q  <= bus.data_addr;
          req_wstrb_q <= bus.data_wstrb;
          req_wdata_q <= bus.data_wdata;
        end else begin
          // Instruction fetch is always a full-word read
          owner_q     <= OWN_IF;
          req_wr_q    <= 1'b0;
          req_size_q  <= SZ_W;
          req_addr_q  <= bus.inst_addr;
          req_wstrb_q <= '0;
          req_wdata_q <= '0;
        end
      end

      if (complete && (owner_q == OWN_IF)) begin
        inst_rdata_q <= bus.mem_rdata;
      end

      // A write acknowledge carries no data; keep the last read value
      if (complete && (owner_q == OWN_MEM) && !req_wr_q) begin
        data_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.inst_addr_ok = accept && grant[OWN_IF];
  assign bus.data_addr_ok = accept && grant[OWN_MEM];

  assign bus.inst_data_ok = inst_data_ok_q;
  assign bus.data_data_ok = data_data_ok_q;
  assign bus.inst_rdata   = inst_rdata_q;
  assign bus.data_rdata   = data_rdata_q;

  // Bus fields come straight from the request registers, so they hold
  // stable for as long as the slave stalls mem_addr_ok.
  assign bus.mem_req   = (state_q == ARB_ISSUE);
  assign bus.mem_wr    = req_wr_q;
  assign bus.mem_size  = req_size_q;
  assign bus.mem_addr  = req_addr_q;
  assign bus.mem_wstrb = req_wstrb_q;
  assign bus.mem_wdata = req_wdata_q;

  assign bus.busy  = !in_idle;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
//   Directed bench for sram_like_arbiter. A table of single transactions
//   (with bus stall counts and hand-computed expected bus fields and rdata)
//   is applied in a loop; hand-written sequences cover contention,
//   arbitration order, back-to-back acceptance and reset during WAIT.
//   Inputs are driven 1 time unit after the rising edge, outputs sampled
//   1 time unit later.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bif ();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.inst_req    = 1'b0;
    bif.inst_addr   = '0;
    bif.data_req    = 1'b0;
    bif.data_wr     = 1'b0;
    bif.data_size   = 2'd0;
    bif.data_addr   = '0;
    bif.data_wstrb  = '0;
    bif.data_wdata  = '0;
    bif.mem_addr_ok = 1'b0;
    bif.mem_data_ok = 1'b0;
    bif.mem_rdata   = '0;
  endtask

  // One transaction record: requester inputs, bus behaviour, expectations
  typedef struct {
    logic        is_mem;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          aw;          // mem_addr_ok wait cycles
    int          dw;          // mem_data_ok wait cycles after addr_ok
    logic        coincide;    // data_ok together with addr_ok
    logic        stray;       // spurious mem_data_ok in IDLE / ISSUE stalls
    logic [31:0] bus_rdata;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_inst_rdata;
    logic [31:0] exp_data_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic run_txn(input int idx, input vec_t v);
    logic [1:0]  own;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    own = v.is_mem ? 2'b10 : 2'b01;

    // Accept cycle: the non-owner's inputs carry junk with req low
    cyc();
    bif.inst_req    = !v.is_mem;
    bif.inst_addr   = v.is_mem ? 32'h1111_1111 : v.addr;
    bif.data_req    = v.is_mem;
    bif.data_wr     = v.wr;
    bif.data_size   = v.size;
    bif.data_addr   = v.is_mem ? v.addr : 32'h2222_2222;
    bif.data_wstrb  = v.wstrb;
    bif.data_wdata  = v.wdata;
    bif.mem_data_ok = v.stray;
    bif.mem_rdata   = 32'hDEAD_BEEF;
    #1;
    check($sformatf("v%0d_addr_ok", idx), 32'({bif.data_addr_ok, bif.inst_addr_ok}), 32'(own));
    check($sformatf("v%0d_idle_data_ok", idx), 32'({bif.data_data_ok, bif.inst_data_ok}), 32'd0);
    check($sformatf("v%0d_idle_mem_req", idx), 32'(bif.mem_req), 32'd0);
    exp_q.push_back(v.is_mem ? v.exp_data_rdata : v.exp_inst_rdata);

    // Requester lets go; scramble its inputs to prove the capture holds
    cyc();
    bif.inst_req   = 1'b0;
    bif.data_req   = 1'b0;
    bif.inst_addr  = 32'hFFFF_FFFF;
    bif.data_addr  = 32'hFFFF_FFFF;
    bif.data_wr    = ~v.wr;
    bif.data_size  = 2'd3;
    bif.data_wstrb = ~v.wstrb;
    bif.data_wdata = ~v.wdata;

    for (int i = 0; i <= v.aw; i++) begin
      bif.mem_addr_ok = (i == v.aw);
      bif.mem_data_ok = (i == v.aw) ? v.coincide : v.stray;
      bif.mem_rdata   = ((i == v.aw) && v.coincide) ? v.bus_rdata : 32'hDEAD_BEEF;
      #1;
      check($sformatf("v%0d_issue%0d_mem_req", idx, i), 32'(bif.mem_req), 32'd1);
      check($sformatf("v%0d_issue%0d_addr", idx, i), bif.mem_addr, v.addr);
      check($sformatf("v%0d_issue%0d_wr", idx, i), 32'(bif.mem_wr), 32'(v.exp_wr));
      check($sformatf("v%0d_issue%0d_size", idx, i), 32'(bif.mem_size), 32'(v.exp_size));
      check($sformatf("v%0d_issue%0d_wstrb", idx, i), 32'(bif.mem_wstrb), 32'(v.exp_wstrb));
      if (v.is_mem) begin
        check($sformatf("v%0d_issue%0d_wdata", idx, i), bif.mem_wdata, v.wdata);
      end
      check($sformatf("v%0d_issue%0d_data_ok", idx, i),
            32'({bif.data_data_ok, bif.inst_data_ok}), 32'd0);
      check($sformatf("v%0d_issue%0d_busy", idx, i), 32'(bif.busy), 32'd1);
      cyc();
    end
    bif.mem_addr_ok = 1'b0;

    if (!v.coincide) begin
      for (int i = 0; i <= v.dw; i++) begin
        bif.mem_data_ok = (i == v.dw);
        bif.mem_rdata   = (i == v.dw) ? v.bus_rdata : 32'hDEAD_BEEF;
        #1;
        check($sformatf("v%0d_wait%0d_mem_req", idx, i), 32'(bif.mem_req), 32'd0);
        check($sformatf("v%0d_wait%0d_state", idx, i), 32'(dbg_state), 32'(ARB_WAIT));
        check($sformatf("v%0d_wait%0d_data_ok", idx, i),
              32'({bif.data_data_ok, bif.inst_data_ok}), 32'd0);
        cyc();
      end
    end

    // Completion cycle
    bif.mem_data_ok = 1'b0;
    bif.mem_rdata   = 32'h0BAD_0BAD;
    #1;
    check($sformatf("v%0d_done_data_ok", idx), 32'({bif.data_data_ok, bif.inst_data_ok}), 32'(own));
    check($sformatf("v%0d_done_busy", idx), 32'(bif.busy), 32'd0);
    check($sformatf("v%0d_done_state", idx), 32'(dbg_state), 32'(ARB_IDLE));
    exp_rd = exp_q.pop_front();
    got_rd = v.is_mem ? bif.data_rdata : bif.inst_rdata;
    check($sformatf("v%0d_owner_rdata", idx), got_rd, exp_rd);
    check($sformatf("v%0d_inst_rdata", idx), bif.inst_rdata, v.exp_inst_rdata);
    check($sformatf("v%0d_data_rdata", idx), bif.data_rdata, v.exp_data_rdata);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [1:0] rr_exp[6];

  initial begin
    //              is_mem wr    size  addr          wstrb wdata         aw dw coin  stray bus_rdata     e_wr  e_sz  e_strb e_inst_rdata  e_data_rdata
    vecs[0] = '{1'b0, 1'b1, 2'd0, 32'hBFC0_0000, 4'hF, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 32'h2408_0001, 1'b0, 2'd2, 4'h0, 32'h2408_0001, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b1, 2'd1, 32'h8000_1000, 4'h3, 32'h0000_BEEF, 3, 0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 2'd1, 4'h3, 32'h2408_0001, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 2'd2, 32'h8000_2004, 4'h0, 32'h0000_0000, 1, 2, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 2'd2, 4'h0, 32'h2408_0001, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h8000_0003, 4'h8, 32'hAA00_0000, 0, 1, 1'b0, 1'b0, 32'h5555_5555, 1'b1, 2'd0, 4'h8, 32'h2408_0001, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b0, 2'd0, 32'h0040_0010, 4'h0, 32'h0000_0000, 0, 0, 1'b1, 1'b0, 32'h8C02_0000, 1'b0, 2'd2, 4'h0, 32'h8C02_0000, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 2'd1, 32'h8000_0002, 4'h0, 32'h0000_0000, 2, 0, 1'b1, 1'b0, 32'h0000_CAFE, 1'b0, 2'd1, 4'h0, 32'h8C02_0000, 32'h0000_CAFE};
    vecs[6] = '{1'b0, 1'b1, 2'd1, 32'h0040_0014, 4'hF, 32'hFFFF_FFFF, 2, 3, 1'b0, 1'b1, 32'h3C1D_8001, 1'b0, 2'd2, 4'h0, 32'h3C1D_8001, 32'h0000_CAFE};

`ifdef SRAM_ARB_RR_EN
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
    rr_exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
`endif

    // ---- reset state --------------------------------------------------------
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_mem_req", 32'(bif.mem_req), 32'd0);
    check("rst_mem_addr", bif.mem_addr, 32'd0);
    check("rst_mem_fields", 32'({bif.mem_wr, bif.mem_size, bif.mem_wstrb}), 32'd0);
    check("rst_mem_wdata", bif.mem_wdata, 32'd0);
    check("rst_oks", 32'({bif.inst_addr_ok, bif.inst_data_ok, bif.data_addr_ok, bif.data_data_ok}), 32'd0);
    check("rst_inst_rdata", bif.inst_rdata, 32'd0);
    check("rst_data_rdata", bif.data_rdata, 32'd0);
    reset = 1'b0;

    // ---- table-driven single transactions ----------------------------------
    for (int i = 0; i < 7; i++) begin
      run_txn(i, vecs[i]);
    end
    idle_inputs();

    // ---- simultaneous requests: MEM first, IF on the following IDLE --------
    cyc();
    bif.inst_req   = 1'b1;
    bif.inst_addr  = 32'hBFC0_0100;
    bif.data_req   = 1'b1;
    bif.data_wr    = 1'b0;
    bif.data_size  = SZ_W;
    bif.data_addr  = 32'h8000_3000;
    bif.data_wstrb = 4'h0;
    #1;
    check("prio_grant", 32'({bif.data_addr_ok, bif.inst_addr_ok}), 32'b10);
    cyc();
    bif.data_req    = 1'b0;
    bif.mem_addr_ok = 1'b1;
    #1;
    check("prio_mem_addr", bif.mem_addr, 32'h8000_3000);
    check("prio_issue_inst_addr_ok", 32'(bif.inst_addr_ok), 32'd0);
    cyc();
    bif.mem_addr_ok = 1'b0;
    bif.mem_data_ok = 1'b1;
    bif.mem_rdata   = 32'hA5A5_0001;
    #1;
    check("prio_wait_inst_addr_ok", 32'(bif.inst_addr_ok), 32'd0);
    cyc();
    bif.mem_data_ok = 1'b0;
    #1;
    // The data_ok cycle is an IDLE cycle: the held IF request is taken now
    check("prio_data_data_ok", 32'(bif.data_data_ok), 32'd1);
    check("prio_data_rdata", bif.data_rdata, 32'hA5A5_0001);
    check("prio_b2b_inst_addr_ok", 32'(bif.inst_addr_ok), 32'd1);
    cyc();
    bif.inst_req    = 1'b0;
    bif.mem_addr_ok = 1'b1;
    #1;
    check("prio_if_mem_addr", bif.mem_addr, 32'hBFC0_0100);
    check("prio_if_mem_wr", 32'(bif.mem_wr), 32'd0);
    cyc();
    bif.mem_addr_ok = 1'b0;
    bif.mem_data_ok = 1'b1;
    bif.mem_rdata   = 32'h5A5A_0002;
    cyc();
    bif.mem_data_ok = 1'b0;
    #1;
    check("prio_inst_data_ok", 32'(bif.inst_data_ok), 32'd1);
    check("prio_inst_rdata", bif.inst_rdata, 32'h5A5A_0002);

    // ---- both requesters hold for six back-to-back transactions ------------
    cyc();
    bif.inst_req  = 1'b1;
    bif.inst_addr = 32'hBFC0_0200;
    bif.data_req  = 1'b1;
    bif.data_addr = 32'h8000_4000;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr%0d_grant", i), 32'({bif.data_addr_ok, bif.inst_addr_ok}), 32'(rr_exp[i]));
      cyc();
      bif.mem_addr_ok = 1'b1;
      #1;
      check($sformatf("rr%0d_mem_addr", i), bif.mem_addr,
            rr_exp[i][1] ? 32'h8000_4000 : 32'hBFC0_0200);
      cyc();
      bif.mem_addr_ok = 1'b0;
      bif.mem_data_ok = 1'b1;
      bif.mem_rdata   = 32'h0000_1000 + i;
      cyc();
      bif.mem_data_ok = 1'b0;
      if (i == 5) begin
        bif.inst_req = 1'b0;
        bif.data_req = 1'b0;
      end
      #1;
      check($sformatf("rr%0d_data_ok", i), 32'({bif.data_data_ok, bif.inst_data_ok}), 32'(rr_exp[i]));
    end

    // ---- reset while in WAIT drops the transaction -------------------------
    cyc();
    bif.data_req  = 1'b1;
    bif.data_wr   = 1'b0;
    bif.data_addr = 32'h8000_5000;
    #1;
    check("rstw_addr_ok", 32'(bif.data_addr_ok), 32'd1);
    cyc();
    bif.data_req    = 1'b0;
    bif.mem_addr_ok = 1'b1;
    cyc();
    bif.mem_addr_ok = 1'b0;
    #1;
    check("rstw_in_wait", 32'(dbg_state), 32'(ARB_WAIT));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    check("rstw_state", 32'(dbg_state), 32'(ARB_IDLE));
    check("rstw_busy", 32'(bif.busy), 32'd0);
    check("rstw_mem_req", 32'(bif.mem_req), 32'd0);
    check("rstw_mem_addr", bif.mem_addr, 32'd0);
    check("rstw_oks", 32'({bif.inst_addr_ok, bif.inst_data_ok, bif.data_addr_ok, bif.data_data_ok}), 32'd0);
    check("rstw_inst_rdata", bif.inst_rdata, 32'd0);
    check("rstw_data_rdata", bif.data_rdata, 32'd0);
    bif.mem_data_ok = 1'b1;
    bif.mem_rdata   = 32'hFEED_FACE;
    cyc();
    bif.mem_data_ok = 1'b0;
    #1;
    check("rstw_late_data_ok", 32'({bif.data_data_ok, bif.inst_data_ok}), 32'd0);
    check("rstw_late_rdata", bif.data_rdata, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
